uart_tx_buffer: RTL and testbench

- Byte FIFO plus handshake sequencer placed directly upstream of the UART transmitter.
- Accepts single-cycle byte writes from the CPU/MMIO side and buffers them.
- Presents one byte at a time to the transmitter on its i_Tx_DV/i_Tx_Byte/o_Tx_Done_l handshake.
- Decouples software writes from the roughly 10×CLKS_PER_BIT cycle frame time.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 66 ++++++
 rtl/uart_tx_buffer.sv | 100 ++++++++++
 tb/tb_uart_tx_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit buffer.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    // Handshake sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous circular byte FIFO with registered full/empty/count flags.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BYTE_W-1:0]     wr_data,
    output logic [BYTE_W-1:0]     head_c,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_n;
    logic              push_ok;
    logic              pop_ok;

    // A push while full is refused even if a pop happens on the same edge
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_n = count - CNT_W'(1);
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus DV/done handshake sequencer feeding a UART transmitter.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  reset,
    input  logic                  i_Wr,
    input  logic [BYTE_W-1:0]     i_Wr_Data,
    input  logic                  i_Clear_Ovf,
    input  logic                  i_Tx_Done,
    output logic                  o_Tx_DV,
    output logic [BYTE_W-1:0]     o_Tx_Byte,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Busy
);

    state_t            state;
    state_t            state_n;
    logic              start_c;
    logic              pop_c;
    logic              dv_n;
    logic [BYTE_W-1:0] byte_n;
    logic [BYTE_W-1:0] head_c;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (i_Clock),
        .reset   (reset),
        .push    (i_Wr),
        .pop     (pop_c),
        .wr_data (i_Wr_Data),
        .head_c  (head_c),
        .full    (o_Full),
        .empty   (o_Empty),
        .count   (o_Count)
    );

    // Launch a frame only when data is waiting and the done flag is low
    assign start_c = (state == S_IDLE) && !o_Empty && !i_Tx_Done;
    assign o_Busy  = !o_Empty || (state != S_IDLE);

    // State and handshake output registers
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state     <= S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
        end else begin
            state     <= state_n;
            o_Tx_DV   <= dv_n;
            o_Tx_Byte <= byte_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start_c)    state_n = S_SEND;
            S_SEND:    if (i_Tx_Done)  state_n = S_RELEASE;
            S_RELEASE: if (!i_Tx_Done) state_n = S_IDLE;
            default:                   state_n = S_IDLE;
        endcase
    end

    // Output logic: pop the head on launch, hold byte while sending
    always_comb begin
        pop_c  = 1'b0;
        dv_n   = 1'b0;
        byte_n = o_Tx_Byte;
        case (state)
            S_IDLE: begin
                if (start_c) begin
                    pop_c  = 1'b1;
                    dv_n   = 1'b1;
                    byte_n = head_c;
                end
            end
            S_SEND:    dv_n = !i_Tx_Done;
            S_RELEASE: dv_n = 1'b0;
            default:   dv_n = 1'b0;
        endcase
    end

    // Sticky overflow; a dropped write wins over a same-edge clear
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            o_Overflow <= 1'b0;
        end else if (i_Wr && o_Full) begin
            o_Overflow <= 1'b1;
        end else if (i_Clear_Ovf) begin
            o_Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench: buffer driving a behavioural UART transmitter and line decoder.
module tb_uart_tx_buffer;

    localparam int unsigned DL2 = 4;
    localparam int unsigned CPB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         clear_ovf = 1'b0;
    logic         force_done = 1'b0;
    logic         tx_done;
    logic         tx_dv;
    logic [7:0]   tx_byte;
    logic         full, empty, ovf, busy;
    logic [DL2:0] count;

    int n_checks = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_buffer #(.DEPTH_LOG2(DL2)) dut (
        .i_Clock     (clk),
        .reset       (reset),
        .i_Wr        (wr),
        .i_Wr_Data   (wr_data),
        .i_Clear_Ovf (clear_ovf),
        .i_Tx_Done   (tx_done),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .o_Busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural transmitter: start, 8 data LSB first, stop, then one-cycle done
    logic [1:0] tx_st;
    logic [9:0] frame;
    int         bitn, cnt;
    logic       line;
    logic       model_done;
    assign tx_done = model_done | force_done;

    always @(posedge clk) begin
        if (reset) begin
            tx_st <= 2'd0; line <= 1'b1; model_done <= 1'b0; bitn <= 0; cnt <= 0;
        end else begin
            model_done <= 1'b0;
            case (tx_st)
                2'd0: if (tx_dv) begin
                    frame <= {1'b1, tx_byte, 1'b0};
                    tx_st <= 2'd1; bitn <= 0; cnt <= 0;
                end
                2'd1: begin
                    line <= frame[bitn];
                    if (cnt == CPB - 1) begin
                        cnt <= 0;
                        if (bitn == 9) begin
                            tx_st <= 2'd2; model_done <= 1'b1;
                        end else begin
                            bitn <= bitn + 1;
                        end
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                default: begin
                    tx_st <= 2'd0; line <= 1'b1;
                end
            endcase
        end
    end

    // Serial-line decoder; each received byte is checked against the scoreboard
    int         rx_c = 0;
    int         rx_cnt = 0;
    logic       rx_act = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    always @(posedge clk) begin
        if (reset) begin
            rx_act <= 1'b0; rx_c <= 0;
        end else if (!rx_act) begin
            if (line == 1'b0) begin
                rx_act <= 1'b1; rx_c <= 1;
            end
        end else begin
            rx_c <= rx_c + 1;
            if (rx_c >= 5 && rx_c <= 33 && (rx_c % 4) == 1)
                rx_sh <= {line, rx_sh[7:1]};
            if (rx_c == 37) begin
                rx_act <= 1'b0;
                rx_cnt <= rx_cnt + 1;
                chk("rx_stop", 32'(line), 32'd1);
                if (sb.size() == 0) chk("rx_extra_byte", 32'(rx_sh), 32'hFFFF_FFFF);
                else chk("rx_byte", 32'(rx_sh), 32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr = 1'b1; wr_data = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        int n;
        int low_cnt;
        int rx_before;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(tx_dv), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte
        sb.push_back(8'h55);
        write_byte(8'h55);
        chk("single_count", 32'(count), 32'd1);
        chk("single_dv_early", 32'(tx_dv), 32'd0);
        @(negedge clk);
        chk("single_dv", 32'(tx_dv), 32'd1);
        chk("single_byte", 32'(tx_byte), 32'h55);
        chk("single_count_popped", 32'(count), 32'd0);
        n = 0;
        while (!tx_done && n < 200) begin @(negedge clk); n++; end
        chk("single_done_timeout", 32'(n < 200), 32'd1);
        chk("single_dv_at_done", 32'(tx_dv), 32'd1);
        @(negedge clk);
        chk("single_dv_drop", 32'(tx_dv), 32'd0);
        wait_drain("single", 100);
        chk("single_busy_idle", 32'(busy), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 18; i++) begin
            if (i < 17) sb.push_back(8'(i));
            wr = 1'b1; wr_data = 8'(i);
            @(negedge clk);
            if (i == 15) chk("fill_not_full", 32'(full), 32'd0);
            if (i == 16) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_count", 32'(count), 32'd16);
                chk("fill_ovf_clear", 32'(ovf), 32'd0);
            end
            if (i == 17) chk("fill_ovf", 32'(ovf), 32'd1);
        end
        wr = 1'b0;

        // Overflow clear race, then plain clear
        wr = 1'b1; wr_data = 8'h77; clear_ovf = 1'b1;
        @(negedge clk);
        wr = 1'b0; clear_ovf = 1'b0;
        chk("race_ovf", 32'(ovf), 32'd1);
        chk("race_count", 32'(count), 32'd16);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("clear_ovf", 32'(ovf), 32'd0);
        wait_drain("fill", 3000);
        chk("fill_sb_empty", 32'(sb.size()), 32'd0);

        // Stale done held high in idle
        force_done = 1'b1;
        sb.push_back(8'hA5);
        write_byte(8'hA5);
        repeat (6) @(negedge clk);
        chk("stale_count", 32'(count), 32'd1);
        chk("stale_dv", 32'(tx_dv), 32'd0);
        chk("stale_busy", 32'(busy), 32'd1);
        force_done = 1'b0;
        @(negedge clk);
        chk("stale_launch_dv", 32'(tx_dv), 32'd1);
        chk("stale_launch_byte", 32'(tx_byte), 32'hA5);
        wait_drain("stale", 200);

        // Reset mid-frame: queued and in-flight bytes are discarded
        write_byte(8'hAA);
        write_byte(8'hBB);
        write_byte(8'hCC);
        n = 0;
        while (!(tx_st == 2'd1 && bitn >= 3) && n < 200) begin @(negedge clk); n++; end
        chk("midrst_wait_timeout", 32'(n < 200), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_dv", 32'(tx_dv), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        rx_before = rx_cnt;
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (line !== 1'b1) low_cnt++;
        end
        chk("midrst_line_idle", 32'(low_cnt), 32'd0);
        chk("midrst_no_rx", 32'(rx_cnt), 32'(rx_before));
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
